// File: rtl/hash_msg_feeder.sv
// Byte feeder for the DES-S-box hash core: takes a length and message bytes from
// upstream, paces them into the core one byte per BYTE_GAP cycles, returns the digest.
module hash_msg_feeder #(
    parameter int BYTE_GAP   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        len_valid,
    input  logic [63:0] len_in,
    output logic        len_ready,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        m_valid,
    output logic [7:0]  message,
    output logic [63:0] counter,
    input  logic        hash_ready,
    input  logic [31:0] digest_out,
    output logic        dig_valid,
    output logic [31:0] dig_data,
    input  logic        dig_ready,
    output logic        busy,
    output logic        err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(BYTE_GAP + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_HASH, OUT} state_t;

    state_t        state_reg, state_next;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg, count_next;
    logic [63:0]   counter_reg, counter_next;
    logic [63:0]   remaining_reg, remaining_next;
    logic [63:0]   accepted_reg, accepted_next;
    logic [GW-1:0] gap_reg, gap_next;
    logic [TW-1:0] tmo_reg, tmo_next;
    logic [31:0]   dig_data_reg, dig_data_next;
    logic [7:0]    message_reg;
    logic          len_ready_reg, len_ready_next;
    logic          in_ready_reg, in_ready_next;
    logic          m_valid_reg, m_valid_next;
    logic          dig_valid_reg, dig_valid_next;
    logic          busy_reg, busy_next;
    logic          err_reg, err_next;
    logic          push, pop;

    always_comb begin
        state_next     = state_reg;
        counter_next   = counter_reg;
        remaining_next = remaining_reg;
        gap_next       = gap_reg;
        tmo_next       = tmo_reg;
        dig_data_next  = dig_data_reg;
        err_next       = 1'b0;

        // in_ready_reg is only ever high in STREAM, so push implies STREAM
        push          = in_valid && in_ready_reg;
        pop           = (state_reg == STREAM) && (gap_reg == '0) && (count_reg != '0);
        m_valid_next  = pop;
        count_next    = count_reg + (AW+1)'(push) - (AW+1)'(pop);
        accepted_next = accepted_reg + {63'd0, push};

        case (state_reg)
            IDLE: begin
                if (len_valid) begin
                    if (len_in == 64'd0) begin
                        err_next = 1'b1;
                    end else begin
                        counter_next   = len_in;
                        remaining_next = len_in;
                        accepted_next  = 64'd0;
                        gap_next       = '0;
                        state_next     = STREAM;
                    end
                end
            end
            STREAM: begin
                if (pop) begin
                    remaining_next = remaining_reg - 64'd1;
                    gap_next       = GW'(BYTE_GAP - 1);
                    if (remaining_reg == 64'd1) begin
                        tmo_next   = '0;
                        state_next = WAIT_HASH;
                    end
                end else if (gap_reg != '0) begin
                    gap_next = gap_reg - GW'(1);
                end
            end
            WAIT_HASH: begin
                if (hash_ready) begin
                    dig_data_next = digest_out;
                    state_next    = OUT;
                end else if (tmo_reg == TW'(TIMEOUT - 1)) begin
                    err_next     = 1'b1;
                    counter_next = 64'd0;
                    state_next   = IDLE;
                end else begin
                    tmo_next = tmo_reg + TW'(1);
                end
            end
            OUT: begin
                if (dig_ready) begin
                    counter_next = 64'd0;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Handshake outputs are registered, so derive them from the next-state view
        len_ready_next = (state_next == IDLE);
        busy_next      = (state_next != IDLE);
        dig_valid_next = (state_next == OUT);
        in_ready_next  = (state_next == STREAM) &&
                         (count_next < (AW+1)'(FIFO_DEPTH)) &&
                         (accepted_next < counter_next);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            counter_reg   <= 64'd0;
            remaining_reg <= 64'd0;
            accepted_reg  <= 64'd0;
            gap_reg       <= '0;
            tmo_reg       <= '0;
            dig_data_reg  <= 32'd0;
            message_reg   <= 8'd0;
            len_ready_reg <= 1'b1;
            in_ready_reg  <= 1'b0;
            m_valid_reg   <= 1'b0;
            dig_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            counter_reg   <= counter_next;
            remaining_reg <= remaining_next;
            accepted_reg  <= accepted_next;
            gap_reg       <= gap_next;
            tmo_reg       <= tmo_next;
            dig_data_reg  <= dig_data_next;
            len_ready_reg <= len_ready_next;
            in_ready_reg  <= in_ready_next;
            m_valid_reg   <= m_valid_next;
            dig_valid_reg <= dig_valid_next;
            busy_reg      <= busy_next;
            err_reg       <= err_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + AW'(1);
                message_reg <= mem[rd_ptr_reg];
            end
        end
    end

    assign len_ready = len_ready_reg;
    assign in_ready  = in_ready_reg;
    assign m_valid   = m_valid_reg;
    assign message   = message_reg;
    assign counter   = counter_reg;
    assign dig_valid = dig_valid_reg;
    assign dig_data  = dig_data_reg;
    assign busy      = busy_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Randomized bench for hash_msg_feeder: a byte-count model predicts every m_valid
// pulse, message byte and in_ready level; directed phases drive the core side.
module tb_hash_msg_feeder;

    localparam int BYTE_GAP = 4;
    localparam int DEPTH    = 8;
    localparam int TMO      = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        len_valid;
    logic [63:0] len_in;
    logic        len_ready;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        m_valid;
    logic [7:0]  message;
    logic [63:0] counter;
    logic        hash_ready;
    logic [31:0] digest_out;
    logic        dig_valid;
    logic [31:0] dig_data;
    logic        dig_ready;
    logic        busy;
    logic        err;

    hash_msg_feeder #(.BYTE_GAP(BYTE_GAP), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .len_valid(len_valid), .len_in(len_in), .len_ready(len_ready),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .m_valid(m_valid), .message(message), .counter(counter),
        .hash_ready(hash_ready), .digest_out(digest_out),
        .dig_valid(dig_valid), .dig_data(dig_data), .dig_ready(dig_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: byte accounting per message
    logic [7:0]  exp_q[$];
    logic [7:0]  tx_q[$];
    longint      n_acc, n_emit, mlen, last_emit, cyc = 0;
    int          acc_last;
    bit          pend_acc = 0, start_pend = 0, active = 0;
    logic [63:0] start_len;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            active     = 0;
            start_pend = 0;
            pend_acc   = 0;
            exp_q.delete();
        end else begin
            cyc++;
            if (start_pend) begin
                active     = 1;
                start_pend = 0;
                mlen       = longint'(start_len);
                n_acc      = 0;
                n_emit     = 0;
                last_emit  = -1000;
            end
            acc_last = pend_acc ? 1 : 0;
            if (pend_acc) n_acc++;
            pend_acc = 0;
            if (active) begin
                check("m_valid", m_valid,
                      (n_acc - acc_last - n_emit > 0) && (n_emit < mlen) &&
                      (cyc - last_emit >= BYTE_GAP));
                if (m_valid) begin
                    if (exp_q.size() == 0) check("msg_extra", 1, 0);
                    else check("message", message, exp_q.pop_front());
                    check("counter", counter, mlen);
                    n_emit++;
                    last_emit = cyc;
                end
                check("in_ready", in_ready, (n_acc < mlen) && (n_acc - n_emit < DEPTH));
                check("stream_busy", busy, 1);
                check("stream_dig_valid", dig_valid, 0);
                check("stream_err", err, 0);
                if (n_emit == mlen) begin
                    active = 0;
                    done_cnt++;
                end
            end else begin
                check("idle_m_valid", m_valid, 0);
                check("idle_in_ready", in_ready, 0);
            end
            if (in_valid && in_ready) begin
                pend_acc = 1;
                exp_q.push_back(in_data);
            end
            if (len_valid && len_ready && len_in != 64'd0 && !active) begin
                start_pend = 1;
                start_len  = len_in;
            end
        end
    end

    task automatic send_len(input logic [63:0] l);
        check("len_ready_pre", len_ready, 1);
        len_valid = 1'b1;
        len_in    = l;
        @(posedge clk); #1;
        len_valid = 1'b0;
        len_in    = {$urandom, $urandom};
        if (l != 64'd0) begin
            check("len_busy", busy, 1);
            check("len_in_ready", in_ready, 1);
            check("len_counter", counter, l);
            check("len_ready_post", len_ready, 0);
        end else begin
            check("zero_err", err, 1);
            check("zero_busy", busy, 0);
            check("zero_len_ready", len_ready, 1);
            @(posedge clk); #1;
            check("zero_err_pulse", err, 0);
            check("zero_busy2", busy, 0);
        end
    endtask

    task automatic send_bytes(input bit rnd, input bit stray);
        for (int i = 0; i < tx_q.size(); i++) begin
            int n;
            bit hs;
            n        = 0;
            hs       = 0;
            in_data  = tx_q[i];
            in_valid = rnd ? ($urandom_range(3) != 0) : 1'b1;
            while (!hs && n < 300) begin
                if (stray) hash_ready = ($urandom_range(3) == 0);
                hs = in_valid && in_ready;
                @(posedge clk); #1;
                n++;
                if (!hs) in_valid = rnd ? ($urandom_range(3) != 0) : 1'b1;
            end
            if (!hs) begin
                check("in_handshake_timeout", 0, 1);
                break;
            end
        end
        in_valid   = 1'b0;
        hash_ready = 1'b0;
    endtask

    task automatic wait_done();
        int start;
        int n;
        start = done_cnt;
        n     = 0;
        while (done_cnt == start && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        if (done_cnt == start) check("emit_done_timeout", 0, 1);
    endtask

    task automatic finish_msg(input logic [31:0] d, input int hdly, input int rdly);
        check("wait_busy", busy, 1);
        check("wait_dig_valid", dig_valid, 0);
        repeat (hdly) begin @(posedge clk); #1; end
        hash_ready = 1'b1;
        digest_out = d;
        @(posedge clk); #1;
        hash_ready = 1'b0;
        digest_out = $urandom;
        check("dig_valid", dig_valid, 1);
        check("dig_data", dig_data, d);
        check("out_len_ready", len_ready, 0);
        repeat (rdly) begin
            @(posedge clk); #1;
            check("dig_valid_hold", dig_valid, 1);
            check("dig_data_hold", dig_data, d);
        end
        dig_ready = 1'b1;
        @(posedge clk); #1;
        dig_ready = 1'b0;
        check("done_dig_valid", dig_valid, 0);
        check("done_len_ready", len_ready, 1);
        check("done_busy", busy, 0);
        check("done_counter", counter, 0);
        $display("msg len=%0d digest=0x%08h", mlen, d);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_len_ready"}, len_ready, 1);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_message"}, message, 0);
        check({tag, "_counter"}, counter, 0);
        check({tag, "_dig_valid"}, dig_valid, 0);
        check({tag, "_dig_data"}, dig_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        int n;
        int len;
        rst_n      = 1'b0;
        len_valid  = 1'b0;
        len_in     = 64'd0;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        hash_ready = 1'b0;
        digest_out = 32'd0;
        dig_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // "abc" with a stray hash_ready in IDLE first
        hash_ready = 1'b1;
        @(posedge clk); #1;
        hash_ready = 1'b0;
        check("stray_idle_dig_valid", dig_valid, 0);
        check("stray_idle_busy", busy, 0);
        tx_q = '{8'h61, 8'h62, 8'h63};
        send_len(64'd3);
        send_bytes(1'b0, 1'b0);
        wait_done();
        finish_msg(32'h4B71DF03, 2, 3);

        // zero length
        send_len(64'd0);
        repeat (3) begin @(posedge clk); #1; check("zero_busy_after", busy, 0); end

        // backpressure: more bytes than the FIFO holds
        tx_q.delete();
        for (int i = 0; i < 20; i++) tx_q.push_back(8'($urandom));
        send_len(64'd20);
        send_bytes(1'b0, 1'b0);
        wait_done();
        finish_msg($urandom, 1, 0);

        // timeout
        tx_q = '{8'hA5};
        send_len(64'd1);
        send_bytes(1'b0, 1'b0);
        wait_done();
        n = 1;
        while (!err && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("timeout_cycles", n, TMO);
        check("timeout_busy", busy, 0);
        check("timeout_counter", counter, 0);
        check("timeout_len_ready", len_ready, 1);
        check("timeout_dig_valid", dig_valid, 0);
        @(posedge clk); #1;
        check("timeout_err_pulse", err, 0);

        // reset mid-stream after two of five bytes emitted
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_len(64'd5);
        send_bytes(1'b0, 1'b0);
        n = 0;
        while (n_emit < 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("pre_reset_emits", n_emit, 2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tx_q = '{8'hC1, 8'hC2};
        send_len(64'd2);
        send_bytes(1'b0, 1'b0);
        wait_done();
        finish_msg(32'hDEADBEEF, 0, 1);

        // randomized messages, some with stray hash_ready during STREAM
        for (int m = 0; m < 6; m++) begin
            len = $urandom_range(24, 1);
            tx_q.delete();
            for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
            send_len(64'(len));
            send_bytes(1'b1, m[0]);
            wait_done();
            finish_msg($urandom, $urandom_range(10), $urandom_range(4));
            repeat ($urandom_range(3)) @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
